// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states and bus-level constants.
package i2c_pkg;

  localparam int   ADDR_W   = 7;
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_WR_DATA   = 3'd3,
    ST_WR_ACK    = 3'd4,
    ST_RD_DATA   = 3'd5,
    ST_RD_ACK    = 3'd6,
    ST_WAIT_STOP = 3'd7
  } i2c_tgt_state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Multi-stage synchronizer for one I2C line plus rise/fall detection on the
// synchronized value. Resets to the idle-high bus level so reset release
// never produces a spurious edge.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Shift the raw line through the synchronizer and remember the last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_line};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = o_level & ~r_prev;
  assign o_fall  = ~o_level & r_prev;

endmodule

// File: rtl/i2c_target.sv
// I2C target (slave): 7-bit address match, byte writes delivered on a pulse
// interface, byte reads requested from the local side. No clock stretching.
//
// Local-side handshake: rx_valid is a one-cycle pulse that marks rx_data as
// freshly updated (no back-pressure). tx_req is a one-cycle pulse; tx_data is
// captured at the end of that same cycle, so it must already be stable while
// tx_req is high. The two pulses never coincide.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [ADDR_W-1:0] TARGET_ADDR = 7'h42,
  parameter int                SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       I2C_SCL,
  inout  wire        I2C_SDA,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  output logic       rw,
  output logic       busy,
  output logic [2:0] o_state
);

  logic w_scl, w_scl_rise, w_scl_fall;
  logic w_sda, w_sda_rise, w_sda_fall;
  logic w_start, w_stop;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk(clk), .rst(rst), .i_line(I2C_SCL),
    .o_level(w_scl), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
  );

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk(clk), .rst(rst), .i_line(I2C_SDA),
    .o_level(w_sda), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
  );

  assign w_start = w_sda_fall & w_scl;
  assign w_stop  = w_sda_rise & w_scl;

  i2c_tgt_state_t r_state, w_nxt_state;
  logic [3:0] r_bit_cnt, w_nxt_cnt;
  logic [7:0] r_shift, w_nxt_shift;
  logic [7:0] r_rx_data, w_nxt_rx_data;
  logic       r_sda_low, w_nxt_sda_low;
  logic       r_rx_valid, w_nxt_rx_valid;
  logic       r_tx_req, w_nxt_tx_req;
  logic       r_rw, w_nxt_rw;
  logic       r_busy, w_nxt_busy;

  // Open-drain output: only ever pull low or release.
  assign I2C_SDA  = r_sda_low ? 1'b0 : 1'bz;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign tx_req   = r_tx_req;
  assign rw       = r_rw;
  assign busy     = r_busy;
  assign o_state  = r_state;

  // State and datapath registers; reset releases SDA immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= 4'd0;
      r_shift    <= 8'd0;
      r_rx_data  <= 8'd0;
      r_sda_low  <= 1'b0;
      r_rx_valid <= 1'b0;
      r_tx_req   <= 1'b0;
      r_rw       <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_bit_cnt  <= w_nxt_cnt;
      r_shift    <= w_nxt_shift;
      r_rx_data  <= w_nxt_rx_data;
      r_sda_low  <= w_nxt_sda_low;
      r_rx_valid <= w_nxt_rx_valid;
      r_tx_req   <= w_nxt_tx_req;
      r_rw       <= w_nxt_rw;
      r_busy     <= w_nxt_busy;
    end
  end

  // Next-state and datapath logic; STOP/START override bit processing.
  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_cnt      = r_bit_cnt;
    w_nxt_shift    = r_shift;
    w_nxt_rx_data  = r_rx_data;
    w_nxt_sda_low  = r_sda_low;
    w_nxt_rx_valid = 1'b0;
    w_nxt_tx_req   = 1'b0;
    w_nxt_rw       = r_rw;
    w_nxt_busy     = r_busy;

    // tx_data is captured at the end of the tx_req cycle.
    if (r_tx_req) w_nxt_shift = tx_data;

    if (w_stop) begin
      w_nxt_state   = ST_IDLE;
      w_nxt_cnt     = 4'd0;
      w_nxt_sda_low = 1'b0;
      w_nxt_busy    = 1'b0;
    end else if (w_start) begin
      // busy is left alone until the new address phase resolves.
      w_nxt_state   = ST_ADDR;
      w_nxt_cnt     = 4'd0;
      w_nxt_sda_low = 1'b0;
    end else begin
      case (r_state)
        ST_ADDR: begin
          if (w_scl_rise) begin
            w_nxt_shift = {r_shift[6:0], w_sda};
            if (r_bit_cnt == 4'd7) begin
              w_nxt_cnt = 4'd0;
              if (r_shift[ADDR_W-1:0] == TARGET_ADDR) begin
                w_nxt_rw    = w_sda;
                w_nxt_busy  = 1'b1;
                w_nxt_state = ST_ADDR_ACK;
              end else begin
                w_nxt_busy  = 1'b0;
                w_nxt_state = ST_WAIT_STOP;
              end
            end else begin
              w_nxt_cnt = r_bit_cnt + 4'd1;
            end
          end
        end
        ST_ADDR_ACK, ST_WR_ACK: begin
          // First fall starts the ACK drive, second fall ends it (writes).
          // Reads leave at the ACK rise; RD_DATA replaces the ACK with the MSB.
          if (w_scl_fall) begin
            if (!r_sda_low) begin
              w_nxt_sda_low = 1'b1;
            end else begin
              w_nxt_sda_low = 1'b0;
              w_nxt_state   = ST_WR_DATA;
            end
          end else if (w_scl_rise && r_rw) begin
            w_nxt_tx_req = 1'b1;
            w_nxt_cnt    = 4'd0;
            w_nxt_state  = ST_RD_DATA;
          end
        end
        ST_WR_DATA: begin
          if (w_scl_rise) begin
            w_nxt_shift = {r_shift[6:0], w_sda};
            if (r_bit_cnt == 4'd7) begin
              w_nxt_rx_data  = {r_shift[6:0], w_sda};
              w_nxt_rx_valid = 1'b1;
              w_nxt_cnt      = 4'd0;
              w_nxt_state    = ST_WR_ACK;
            end else begin
              w_nxt_cnt = r_bit_cnt + 4'd1;
            end
          end
        end
        ST_RD_DATA: begin
          // Count rises; on each fall present the next bit (MSB first).
          if (w_scl_rise) begin
            if (r_bit_cnt != 4'd8) w_nxt_cnt = r_bit_cnt + 4'd1;
          end else if (w_scl_fall) begin
            if (r_bit_cnt == 4'd0) begin
              w_nxt_sda_low = ~r_shift[7];
            end else if (r_bit_cnt == 4'd8) begin
              w_nxt_sda_low = 1'b0;
              w_nxt_cnt     = 4'd0;
              w_nxt_state   = ST_RD_ACK;
            end else begin
              w_nxt_shift   = {r_shift[6:0], 1'b0};
              w_nxt_sda_low = ~r_shift[6];
            end
          end
        end
        ST_RD_ACK: begin
          if (w_scl_rise) begin
            if (w_sda == I2C_ACK) begin
              w_nxt_tx_req = 1'b1;
              w_nxt_cnt    = 4'd0;
              w_nxt_state  = ST_RD_DATA;
            end else begin
              w_nxt_state  = ST_WAIT_STOP;
            end
          end
        end
        default: begin
          // IDLE and WAIT_STOP only react to START/STOP.
        end
      endcase
    end
  end

endmodule
